// File: rtl/fp_exp_align.sv
// Exponent compare and multi-cycle mantissa alignment for the FP adder datapath.
// Picks the larger operand, then right-shifts the smaller mantissa keeping guard/round/sticky.
module fp_exp_align #(
  parameter int unsigned EXP_W      = 8,
  parameter int unsigned MAN_W      = 24,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic [MAN_W-1:0]   man_a,
  input  logic [MAN_W-1:0]   man_b,
  output logic               busy,
  output logic               done,
  output logic               swap,
  output logic [EXP_W-1:0]   exp_out,
  output logic [EXP_W-1:0]   exp_diff,
  output logic [MAN_W-1:0]   man_large,
  output logic [MAN_W+2:0]   man_small
);

  localparam int unsigned MS_W = MAN_W + 32'd3;
  localparam logic [EXP_W-1:0] STEP_E = SHIFT_STEP[EXP_W-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [EXP_W-1:0]  exp_a_r, exp_b_r, rem_r, rem_s, k_s;
  logic [MAN_W-1:0]  man_a_r, man_b_r;
  logic              swap_s;
  logic [EXP_W-1:0]  big_exp_s, small_exp_s, diff_s;
  logic [MAN_W-1:0]  big_man_s, small_man_s;
  logic [MS_W-1:0]   man_small_s, lost_mask_s;

  // Operand ordering: the larger operand is always the minuend, so diff never wraps.
  always_comb begin
    swap_s = (exp_b_r > exp_a_r) || ((exp_b_r == exp_a_r) && (man_b_r > man_a_r));
    if (swap_s) begin
      big_exp_s   = exp_b_r;
      small_exp_s = exp_a_r;
      big_man_s   = man_b_r;
      small_man_s = man_a_r;
    end else begin
      big_exp_s   = exp_a_r;
      small_exp_s = exp_b_r;
      big_man_s   = man_a_r;
      small_man_s = man_b_r;
    end
    diff_s = big_exp_s - small_exp_s;
  end

  // Per-cycle shift amount and the mask of bits falling off the right end.
  always_comb begin
    if (32'(rem_r) > SHIFT_STEP) begin
      k_s = STEP_E;
    end else begin
      k_s = rem_r;
    end
    lost_mask_s = ~({MS_W{1'b1}} << k_s);
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    man_small_s = man_small;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CMP;
        end else begin
          state_s = IDLE;
        end
      end
      CMP: begin
        rem_s       = diff_s;
        man_small_s = {small_man_s, 3'b000};
        if (diff_s == {EXP_W{1'b0}}) begin
          state_s = FIN;
        end else if (32'(diff_s) >= MS_W) begin
          man_small_s = {{(MS_W-1){1'b0}}, |small_man_s};
          state_s     = FIN;
        end else begin
          state_s = SHIFT;
        end
      end
      SHIFT: begin
        man_small_s = (man_small >> k_s) | {{(MS_W-1){1'b0}}, |(man_small & lost_mask_s)};
        rem_s       = rem_r - k_s;
        if (rem_s == {EXP_W{1'b0}}) begin
          state_s = FIN;
        end else begin
          state_s = SHIFT;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand capture and registered outputs; done trails the FIN cycle by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rem_r     <= {EXP_W{1'b0}};
      exp_a_r   <= {EXP_W{1'b0}};
      exp_b_r   <= {EXP_W{1'b0}};
      man_a_r   <= {MAN_W{1'b0}};
      man_b_r   <= {MAN_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      swap      <= 1'b0;
      exp_out   <= {EXP_W{1'b0}};
      exp_diff  <= {EXP_W{1'b0}};
      man_large <= {MAN_W{1'b0}};
      man_small <= {MS_W{1'b0}};
    end else begin
      state_r   <= state_s;
      rem_r     <= rem_s;
      man_small <= man_small_s;
      busy      <= (state_s == CMP) || (state_s == SHIFT);
      done      <= (state_r == FIN);
      if ((state_r == IDLE) && start) begin
        exp_a_r <= exp_a;
        exp_b_r <= exp_b;
        man_a_r <= man_a;
        man_b_r <= man_b;
      end
      if (state_r == CMP) begin
        swap      <= swap_s;
        exp_out   <= big_exp_s;
        exp_diff  <= diff_s;
        man_large <= big_man_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_exp_align.sv
// Directed self-checking bench for fp_exp_align (SHIFT_STEP=1 and SHIFT_STEP=4 instances).
module tb_fp_exp_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  exp_a, exp_b;
  logic [23:0] man_a, man_b;

  logic        busy, done, swap;
  logic [7:0]  exp_out, exp_diff;
  logic [23:0] man_large;
  logic [26:0] man_small;

  logic        busy4, done4, swap4;
  logic [7:0]  exp_out4, exp_diff4;
  logic [23:0] man_large4;
  logic [26:0] man_small4;

  int checks = 0;
  int errors = 0;
  int lat1, lat4, nd1, nd4;
  logic busy_cmp, busy_fin, b_prev;

  always #5 clk = ~clk;

  fp_exp_align #(.EXP_W(8), .MAN_W(24), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
    .busy(busy), .done(done), .swap(swap), .exp_out(exp_out),
    .exp_diff(exp_diff), .man_large(man_large), .man_small(man_small)
  );

  fp_exp_align #(.EXP_W(8), .MAN_W(24), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
    .busy(busy4), .done(done4), .swap(swap4), .exp_out(exp_out4),
    .exp_diff(exp_diff4), .man_large(man_large4), .man_small(man_small4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Issue one request (called at a negedge), then watch 40 cycles for done on both instances.
  task automatic run(input logic [7:0] ea, input logic [7:0] eb,
                     input logic [23:0] ma, input logic [23:0] mb, input bit poke);
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = 0; lat4 = 0; nd1 = 0; nd4 = 0;
    busy_cmp = 1'b0; busy_fin = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      b_prev = busy;
      @(posedge clk); #1;
      if (c == 1) busy_cmp = busy;
      if (done) begin
        nd1++;
        if (lat1 == 0) begin
          lat1 = c;
          busy_fin = b_prev;
        end
      end
      if (done4) begin
        nd4++;
        if (lat4 == 0) lat4 = c;
      end
      if (poke && c == 2) begin
        start = 1'b1;
        exp_a = 8'd3; exp_b = 8'd90; man_a = 24'h123456; man_b = 24'hFFFFFF;
      end
      if (poke && c == 3) start = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    exp_a = 8'd0; exp_b = 8'd0; man_a = 24'd0; man_b = 24'd0;
    #1;
    chk("reset_outputs", {5'd0, busy, done, swap, exp_out, exp_diff, man_small[7:0]}, 32'd0);
    chk("reset_man", {5'd0, man_large, 3'd0} | {5'd0, man_small}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during the 3rd shift cycle aborts the operation.
    exp_a = 8'd0; exp_b = 8'd20; man_a = 24'h800000; man_b = 24'h800000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_shift_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_done_swap", {29'd0, busy, done, swap}, 32'd0);
    chk("rst_exp", {16'd0, exp_out, exp_diff}, 32'd0);
    chk("rst_man_large", {8'd0, man_large}, 32'd0);
    chk("rst_man_small", {5'd0, man_small}, 32'd0);
    chk("rst_state", {30'd0, dut.state_r}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd1 = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) nd1++;
    end
    chk("rst_no_done", nd1, 32'd0);
    @(negedge clk);

    // Basic swap after reset recovery.
    run(8'd120, 8'd125, 24'h800000, 24'hC00000, 1'b0);
    chk("basic_lat", lat1, 32'd7);
    chk("basic_swap", {31'd0, swap}, 32'd1);
    chk("basic_exp_out", {24'd0, exp_out}, 32'd125);
    chk("basic_exp_diff", {24'd0, exp_diff}, 32'd5);
    chk("basic_man_large", {8'd0, man_large}, 32'h00C00000);
    chk("basic_man_small", {5'd0, man_small}, 32'h00200000);
    chk("basic_lat4", lat4, 32'd4);
    chk("basic_man_small4", {5'd0, man_small4}, 32'h00200000);
    chk("basic_busy_cmp", {31'd0, busy_cmp}, 32'd1);
    chk("basic_busy_fin", {31'd0, busy_fin}, 32'd0);

    // Sticky capture from a set bit shifted past the guard bits.
    run(8'd120, 8'd125, 24'h800001, 24'hC00000, 1'b0);
    chk("sticky_man_small", {5'd0, man_small}, 32'h00200001);
    chk("sticky_lat", lat1, 32'd7);
    chk("sticky_man_small4", {5'd0, man_small4}, 32'h00200001);
    chk("sticky_lat4", lat4, 32'd4);

    // Equal exponents, mantissa tie-break.
    run(8'd100, 8'd100, 24'h900000, 24'hA00000, 1'b0);
    chk("eq_swap", {31'd0, swap}, 32'd1);
    chk("eq_exp_diff", {24'd0, exp_diff}, 32'd0);
    chk("eq_man_large", {8'd0, man_large}, 32'h00A00000);
    chk("eq_man_small", {5'd0, man_small}, 32'h04800000);
    chk("eq_lat", lat1, 32'd2);
    chk("eq_lat4", lat4, 32'd2);

    run(8'd100, 8'd100, 24'hA00000, 24'hA00000, 1'b0);
    chk("tie_swap", {31'd0, swap}, 32'd0);
    chk("tie_man_small", {5'd0, man_small}, 32'h05000000);

    // Saturation: difference exceeds the shifter width.
    run(8'd10, 8'd200, 24'h800000, 24'h900000, 1'b0);
    chk("sat_exp_diff", {24'd0, exp_diff}, 32'd190);
    chk("sat_exp_out", {24'd0, exp_out}, 32'd200);
    chk("sat_man_small", {5'd0, man_small}, 32'd1);
    chk("sat_lat", lat1, 32'd2);

    run(8'd10, 8'd200, 24'h000000, 24'h900000, 1'b0);
    chk("sat_zero_man_small", {5'd0, man_small}, 32'd0);

    // Start pulsed while busy is ignored.
    run(8'd120, 8'd125, 24'h800000, 24'hC00000, 1'b1);
    chk("hs_done_count", nd1, 32'd1);
    chk("hs_exp_out", {24'd0, exp_out}, 32'd125);
    chk("hs_exp_diff", {24'd0, exp_diff}, 32'd5);
    chk("hs_man_small", {5'd0, man_small}, 32'h00200000);
    chk("hs_busy_fin", {31'd0, busy_fin}, 32'd0);
    chk("hs_lat", lat1, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_exp_align.md
Name: fp_exp_align

Overview:
- Parametrised successor to the floating-point small (exponent) ALU.
- Compares two biased exponents and registers the larger exponent and the absolute difference.
- Shifts the smaller operand's mantissa right by that difference over multiple cycles, keeping guard/round/sticky bits.
- Sits between FP operand unpack and the big (mantissa) ALU of the FP adder datapath, using a start/busy/done handshake.

Parameters:
- EXP_W, 8, exponent width in bits (unsigned, biased).
- MAN_W, 24, mantissa width including hidden bit.
- SHIFT_STEP, 1, maximum right-shift bits per cycle; power of two, 1..MAN_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- exp_a  in  EXP_W  operand A exponent
- exp_b  in  EXP_W  operand B exponent
- man_a  in  MAN_W  operand A mantissa
- man_b  in  MAN_W  operand B mantissa
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; results valid
- swap  out  1  1 = operand B is the larger
- exp_out  out  EXP_W  larger exponent
- exp_diff  out  EXP_W  |exp_a - exp_b|
- man_large  out  MAN_W  mantissa of the larger operand
- man_small  out  MAN_W+3  aligned smaller mantissa {mantissa, G, R, S}

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs and internal registers cleared to 0. Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, CMP, SHIFT, FIN.
- IDLE:
  - start=1 at an edge: capture all operand inputs; go to CMP; busy=1.
  - Inputs are ignored while busy, including any start.
- CMP (1 cycle):
  - swap=1 if exp_b>exp_a, or exponents are equal and man_b>man_a; otherwise swap=0.
  - exp_out = larger exponent; exp_diff = larger exponent minus smaller exponent.
  - man_large = larger operand's mantissa; man_small = {smaller mantissa, 3'b000}; remaining = exp_diff.
  - Next state:
    - remaining=0: go to FIN.
    - remaining >= MAN_W+3 (saturation): set man_small = {MAN_W+2 zeros, |smaller mantissa}; go to FIN.
    - Otherwise: go to SHIFT.
- SHIFT:
  - Each cycle, k = min(SHIFT_STEP, remaining).
  - man_small <= (man_small >> k) | (OR of the k bits shifted out, placed in bit 0). Bit 0 is sticky-preserving.
  - remaining <= remaining - k; when the new remaining = 0, go to FIN.
- FIN (1 cycle): done=1, busy=0; return to IDLE.
- Latency, counted from the start-sampling edge to the edge where done is visible:
  - Normal: 2 + ceil(d/SHIFT_STEP) cycles.
  - d=0: 2 cycles.
  - Saturated: 2 cycles.
- Result outputs hold their values after done until the next accepted start's CMP cycle.
- All arithmetic is unsigned. exp_diff never wraps because the larger operand is always subtracted from.
- start may be asserted in the same cycle FIN completes. It is sampled once state is IDLE, giving at most one accepted start per 3+ cycles.

Test Plan:
- Reset mid-SHIFT: exp_a=0, exp_b=20, SHIFT_STEP=1; drop rst_n during the 3rd shift cycle -> immediately all outputs 0, state IDLE, no done. Then start a new request -> completes normally.
- Basic swap, SHIFT_STEP=1: exp_a=120, exp_b=125, man_a=24'h800000, man_b=24'hC00000 -> done after 7 cycles; swap=1, exp_out=125, exp_diff=5, man_large=24'hC00000, man_small=27'h0200000.
- Sticky capture: same as above but man_a=24'h800001 -> man_small=27'h0200001. Repeat with SHIFT_STEP=4 -> same result, done after 4 cycles.
- Equal exponents with mantissa tie-break: exp_a=exp_b=100, man_a=24'h900000, man_b=24'hA00000 -> swap=1, exp_diff=0, man_small=27'h4800000, done after 2 cycles. Repeat with identical mantissas -> swap=0.
- Saturation: exp_a=10, exp_b=200, man_a=24'h800000 -> exp_diff=190, man_small=27'h0000001, done after 2 cycles. Repeat with man_a=0 -> man_small=0.
- Handshake: pulse start again while busy with different operands -> ignored; results match the first request only; exactly one done pulse; busy low in the FIN cycle.
